rst_seq_ctrl: RTL and testbench
===============================

RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 5: number of reset domains; legal range 1..8.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth per domain; legal range 2..4.
REQ-003 SHALL have parameter PLL_RST_CYC, default 8: extClock cycles pll_areset is held.
REQ-004 SHALL have parameter LOCK_STABLE_CYC, default 1024: consecutive locked cycles required before release.
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 65536: WAIT_LOCK cycles before the PLL is re-reset.
REQ-006 SHALL have parameter STEP_DLY, default 16: extClock cycles between successive domain releases.
REQ-007 SHALL have port extClock  in  1  system reference clock; all FSM logic runs on it.
REQ-008 SHALL have port ext_rst_n  in  1  external reset, asynchronous, active-low.
REQ-009 SHALL have port dom_clk  in  NUM_DOMAINS  per-domain clocks, typically PLL outputs.
REQ-010 SHALL have port pll_locked  in  1  PLL lock, asynchronous to extClock.
REQ-011 SHALL have port soft_rst_req  in  1  single-cycle request on extClock to re-sequence domain resets.
REQ-012 SHALL have port pll_areset  out  1  active-high PLL reset.
REQ-013 SHALL have port dom_rst_n  out  NUM_DOMAINS  per-domain reset, active-low, synchronous release on dom_clk[i].
REQ-014 SHALL have port seq_state  out  2  FSM state: 0 PLL_RST, 1 WAIT_LOCK, 2 RELEASE, 3 RUN.
REQ-015 SHALL have port seq_done  out  1  high only in RUN.
REQ-016 SHALL have port lock_lost_cnt  out  8  saturating count of lock-loss events.

Function
REQ-017 SHALL internally synchronise ext_rst_n onto extClock with 2 flops: asynchronous assert, synchronous release.
REQ-018 SHALL synchronise pll_locked onto extClock with 2 flops to form lock_s.
REQ-019 SHALL, in PLL_RST, drive pll_areset=1 for PLL_RST_CYC cycles, then enter WAIT_LOCK.
REQ-020 SHALL, in WAIT_LOCK, drive pll_areset=0 and count consecutive lock_s=1 cycles; the count clears whenever lock_s=0.
REQ-021 SHALL enter RELEASE on the cycle the stable count reaches LOCK_STABLE_CYC.
REQ-022 SHALL return to PLL_RST if WAIT_LOCK lasts LOCK_TIMEOUT cycles without qualifying lock.
REQ-023 SHALL, in RELEASE, set internal release bit rel[k] after (k+1)*STEP_DLY cycles, in ascending order k=0..NUM_DOMAINS-1.
REQ-024 SHALL enter RUN on the cycle after rel[NUM_DOMAINS-1] is set; seq_done=1 from that cycle.
REQ-025 SHALL, on lock_s=0 in RELEASE or RUN, clear all rel bits in the same cycle, increment lock_lost_cnt (saturate at 255), and enter PLL_RST.
REQ-026 SHALL, on soft_rst_req in RELEASE or RUN, clear all rel bits and restart RELEASE from step 0 without resetting the PLL.
REQ-027 SHALL ignore soft_rst_req in PLL_RST and WAIT_LOCK.
REQ-028 SHALL apply priority ext_rst_n > lock loss > soft_rst_req when events coincide; lock loss with soft_rst_req counts once and goes to PLL_RST.
REQ-029 SHALL drive dom_rst_n[i] from a SYNC_STAGES-deep chain on dom_clk[i], asynchronously cleared whenever rel[i]=0 or ext_rst_n=0, with input 1.
REQ-030 SHALL release dom_rst_n[i] exactly SYNC_STAGES dom_clk[i] rising edges after rel[i] rises, assuming dom_clk[i] is running.
REQ-031 SHALL keep dom_rst_n[i] asserted, without glitching high, while dom_clk[i] is stopped.

Reset
REQ-032 SHALL, while ext_rst_n=0: pll_areset=1, dom_rst_n=all 0, seq_state=0, seq_done=0, lock_lost_cnt=0, all counters and rel bits 0.
REQ-033 SHALL, after ext_rst_n rises, start PLL_RST counting on the 3rd extClock edge, after the 2-flop release.
REQ-034 SHALL honour ext_rst_n assertion mid-sequence in any state immediately and asynchronously.

Verification
REQ-035 Defaults, pll_locked tied 1 after reset -> pll_areset high 8 cycles; RELEASE after 1024 + sync cycles; dom_rst_n[0..4] rise in order 16 cycles apart plus 2 dom_clk edges each; seq_done=1.
REQ-036 pll_locked dropped for 1 cycle at 500 cycles into WAIT_LOCK -> stable count restarts; RELEASE entered 1024 cycles after lock resumes.
REQ-037 pll_locked dropped in RUN -> all dom_rst_n low within 1 extClock plus async clear; lock_lost_cnt=1; seq_state=0; full re-sequence follows.
REQ-038 soft_rst_req in RUN -> all dom_rst_n low, pll_areset stays 0, re-release from domain 0; soft_rst_req in WAIT_LOCK -> no effect.
REQ-039 pll_locked held 0 -> WAIT_LOCK times out after 65536 cycles, then PLL_RST repeats; 300 induced lock losses -> lock_lost_cnt=255.
REQ-040 ext_rst_n pulsed low during RELEASE at domain 2 -> all outputs return to reset values immediately; with dom_clk[3] stopped, dom_rst_n[3] stays 0.

Source files
------------

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds the PLL in reset, qualifies lock, then releases the
// per-domain resets one by one, each re-synchronised onto its own clock.
module rst_seq_ctrl #(
    parameter int NUM_DOMAINS     = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int PLL_RST_CYC     = 8,
    parameter int LOCK_STABLE_CYC = 1024,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int STEP_DLY        = 16
) (
    input  logic                   extClock,
    input  logic                   ext_rst_n,
    input  logic [NUM_DOMAINS-1:0] dom_clk,
    input  logic                   pll_locked,
    input  logic                   soft_rst_req,
    output logic                   pll_areset,
    output logic [NUM_DOMAINS-1:0] dom_rst_n,
    output logic [1:0]             seq_state,
    output logic                   seq_done,
    output logic [7:0]             lock_lost_cnt
);

    localparam int CNT_MAX = (PLL_RST_CYC > LOCK_TIMEOUT)
                           ? ((PLL_RST_CYC > STEP_DLY) ? PLL_RST_CYC : STEP_DLY)
                           : ((LOCK_TIMEOUT > STEP_DLY) ? LOCK_TIMEOUT : STEP_DLY);
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int STB_W = $clog2(LOCK_STABLE_CYC + 1);
    localparam logic [NUM_DOMAINS-1:0] REL_FIRST = NUM_DOMAINS'(1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    logic [1:0]             rst_sync;
    logic                   sys_rst_n;
    logic                   lock_meta;
    logic                   lock_s;
    state_t                 state;
    state_t                 state_d;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_d;
    logic [STB_W-1:0]       stable_cnt;
    logic [STB_W-1:0]       stable_d;
    logic [NUM_DOMAINS-1:0] rel;
    logic [NUM_DOMAINS-1:0] rel_d;
    logic [7:0]             lost_cnt;
    logic [7:0]             lost_d;

    // Assert asynchronously with ext_rst_n, release two extClock edges later.
    always_ff @(posedge extClock or negedge ext_rst_n) begin
        if (!ext_rst_n) rst_sync <= '0;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign sys_rst_n = rst_sync[1];

    always_ff @(posedge extClock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // NOTE: every output of this block is defaulted first so no path infers a latch.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt + CNT_W'(1);
        stable_d = stable_cnt;
        rel_d    = rel;
        lost_d   = lost_cnt;
        case (state)
            PLL_RST: begin
                if (cnt == CNT_W'(PLL_RST_CYC - 1)) begin
                    state_d  = WAIT_LOCK;
                    cnt_d    = '0;
                    stable_d = '0;
                end
            end
            WAIT_LOCK: begin
                stable_d = lock_s ? stable_cnt + STB_W'(1) : '0;
                if (lock_s && stable_cnt == STB_W'(LOCK_STABLE_CYC - 1)) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    rel_d   = '0;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                end
            end
            default: begin
                // Lock loss outranks a coincident soft request.
                if (!lock_s) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    rel_d   = '0;
                    if (lost_cnt != 8'hFF) lost_d = lost_cnt + 8'd1;
                end else if (soft_rst_req) begin
                    state_d = RELEASE;
                    cnt_d   = '0;
                    rel_d   = '0;
                end else if (state == RUN) begin
                    cnt_d = cnt;
                end else if (rel[NUM_DOMAINS-1]) begin
                    state_d = RUN;
                    cnt_d   = cnt;
                end else if (cnt == CNT_W'(STEP_DLY - 1)) begin
                    rel_d = (rel << 1) | REL_FIRST;
                    cnt_d = '0;
                end
            end
        endcase
    end

    // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
    always_ff @(posedge extClock or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= PLL_RST;
            cnt        <= '0;
            stable_cnt <= '0;
            rel        <= '0;
            lost_cnt   <= '0;
            pll_areset <= 1'b1;
            seq_done   <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            stable_cnt <= stable_d;
            rel        <= rel_d;
            lost_cnt   <= lost_d;
            pll_areset <= (state_d == PLL_RST);
            seq_done   <= (state_d == RUN);
        end
    end

    assign seq_state     = state;
    assign lock_lost_cnt = lost_cnt;

    for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
        logic                   clr_n;
        logic [SYNC_STAGES-1:0] chain;

        // NOTE: the chain clears without a clock, so a stopped dom_clk still holds its reset low.
        assign clr_n = rel[i] & ext_rst_n;

        always_ff @(posedge dom_clk[i] or negedge clr_n) begin
            if (!clr_n) chain <= '0;
            else        chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end

        assign dom_rst_n[i] = chain[SYNC_STAGES-1];
    end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: a phase/elapsed-time model is compared every cycle,
// and directed scenarios pin the model with hand-computed cycle counts.
module tb_rst_seq_ctrl;

    localparam int ND   = 5;
    localparam int SS   = 2;
    localparam int PLL  = 8;
    localparam int STB  = 64;
    localparam int TMO  = 300;
    localparam int STEP = 16;

    logic          extClock     = 1'b0;
    logic          ext_rst_n    = 1'b1;
    wire  [ND-1:0] dom_clk;
    logic          pll_locked   = 1'b1;
    logic          soft_rst_req = 1'b0;
    logic          pll_areset;
    logic [ND-1:0] dom_rst_n;
    logic [1:0]    seq_state;
    logic          seq_done;
    logic [7:0]    lock_lost_cnt;
    logic [ND-1:0] dom_en = '1;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    rst_seq_ctrl #(
        .NUM_DOMAINS    (ND),
        .SYNC_STAGES    (SS),
        .PLL_RST_CYC    (PLL),
        .LOCK_STABLE_CYC(STB),
        .LOCK_TIMEOUT   (TMO),
        .STEP_DLY       (STEP)
    ) dut (
        .extClock     (extClock),
        .ext_rst_n    (ext_rst_n),
        .dom_clk      (dom_clk),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .pll_areset   (pll_areset),
        .dom_rst_n    (dom_rst_n),
        .seq_state    (seq_state),
        .seq_done     (seq_done),
        .lock_lost_cnt(lock_lost_cnt)
    );

    // extClock edges fall on even times; domain clock edges only on odd times.
    always #10 extClock = ~extClock;

    // ---------------- behavioural model ----------------
    int            m_sync   = 0;
    int            m_phase  = 0;   // 0 PLL reset, 1 waiting for lock, 2 releasing/running
    int            m_t      = 0;   // edges spent in the current phase
    int            m_stable = 0;
    int            m_lost   = 0;
    bit [1:0]      m_hist   = '0;  // pll_locked as seen through two sampling stages
    logic [ND-1:0] m_rel    = '0;
    int            rel_gen[ND];
    wire  [ND-1:0] exp_dom;

    initial for (int i = 0; i < ND; i++) rel_gen[i] = 0;

    function automatic logic [1:0] exp_state();
        if (m_phase == 0) return 2'd0;
        if (m_phase == 1) return 2'd1;
        return (m_t > ND * STEP) ? 2'd3 : 2'd2;
    endfunction

    always @(posedge extClock or negedge ext_rst_n) begin
        bit            lk;
        int            released;
        logic [ND-1:0] nrel;
        if (!ext_rst_n) begin
            m_sync = 0; m_phase = 0; m_t = 0; m_stable = 0; m_lost = 0; m_hist = '0;
            m_rel  = '0;
        end else if (m_sync < 2) begin
            m_sync++;
        end else begin
            lk     = m_hist[1];
            m_hist = {m_hist[0], pll_locked};
            case (m_phase)
                0: begin
                    m_t++;
                    if (m_t == PLL) begin m_phase = 1; m_t = 0; m_stable = 0; end
                end
                1: begin
                    m_t++;
                    m_stable = lk ? m_stable + 1 : 0;
                    if (m_stable == STB) begin m_phase = 2; m_t = 0; end
                    else if (m_t == TMO) begin m_phase = 0; m_t = 0; end
                end
                default: begin
                    if (!lk) begin
                        m_lost  = (m_lost < 255) ? m_lost + 1 : 255;
                        m_phase = 0; m_t = 0;
                    end else if (soft_rst_req) begin
                        m_t = 0;
                    end else if (m_t <= ND * STEP) begin
                        m_t++;
                    end
                end
            endcase
            released = (m_phase == 2) ? ((m_t / STEP < ND) ? m_t / STEP : ND) : 0;
            for (int g = 0; g < ND; g++) begin
                nrel[g] = (g < released);
                if (nrel[g] && !m_rel[g]) rel_gen[g]++;
            end
            m_rel = nrel;
        end
    end

    // Per domain: clock generator, and edge count since that domain's release rose.
    for (genvar g = 0; g < ND; g++) begin : g_dm
        logic ck   = 1'b0;
        int   dcnt = 0;
        int   seen = 0;

        initial begin
            #1;
            forever begin
                #(2 * (g + 1));
                if (dom_en[g]) ck = ~ck;
            end
        end
        assign dom_clk[g] = ck;

        always @(posedge dom_clk[g]) begin
            if (!m_rel[g]) begin
                dcnt = 0;
            end else begin
                if (seen != rel_gen[g]) begin seen = rel_gen[g]; dcnt = 0; end
                if (dcnt < SS) dcnt++;
            end
        end
        assign exp_dom[g] = m_rel[g] && (seen == rel_gen[g]) && (dcnt >= SS);
    end

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge extClock) begin
        if (cmp_en) begin
            check("model_seq_state",  32'(seq_state),     32'(exp_state()));
            check("model_seq_done",   32'(seq_done),      32'(exp_state() == 2'd3));
            check("model_pll_areset", 32'(pll_areset),    32'(m_phase == 0));
            check("model_lost_cnt",   32'(lock_lost_cnt), 32'(m_lost));
            check("model_dom_rst_n",  32'(dom_rst_n),     32'(exp_dom));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge extClock);
        #2;
    endtask

    // Counts extClock edges until seq_state shows s; a missed bound is a failed check.
    task automatic wait_for_state(input logic [1:0] s, input int max, output int n);
        bit hit = 1'b0;
        n = 0;
        while (n < max && !hit) begin
            @(posedge extClock);
            n++;
            @(negedge extClock);
            hit = (seq_state == s);
        end
        check("reach_state", 32'(hit), 32'd1);
    endtask

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #4 ext_rst_n = 1'b0;
        #1 cmp_en = 1'b1;
        tick(3);

        // Reset values.
        check("rst_pll_areset", 32'(pll_areset),    32'd1);
        check("rst_seq_state",  32'(seq_state),     32'd0);
        check("rst_seq_done",   32'(seq_done),      32'd0);
        check("rst_lost_cnt",   32'(lock_lost_cnt), 32'd0);
        check("rst_dom_rst_n",  32'(dom_rst_n),     32'd0);

        // Full power-up sequence with lock held.
        ext_rst_n = 1'b1;
        wait_for_state(2'd1, 40, n);  check("pup_wait_lock_edge", 32'(n), 32'd10);
        wait_for_state(2'd2, 100, n); check("pup_release_edges",  32'(n), 32'd64);
        wait_for_state(2'd3, 120, n); check("pup_run_edges",      32'(n), 32'd81);
        tick(3);
        check("pup_dom_all", 32'(dom_rst_n), 32'h1F);
        check("pup_done",    32'(seq_done),  32'd1);

        // Lock lost in RUN.
        pll_locked = 1'b0;
        wait_for_state(2'd0, 10, n);  check("loss_detect_edges", 32'(n), 32'd3);
        check("loss_lost_cnt", 32'(lock_lost_cnt), 32'd1);
        check("loss_dom_low",  32'(dom_rst_n),     32'd0);
        pll_locked = 1'b1;
        wait_for_state(2'd3, 200, n); check("loss_reseq_edges", 32'(n), 32'd153);

        // Soft request in RUN.
        tick(3);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        check("soft_state",  32'(seq_state),  32'd2);
        check("soft_dom",    32'(dom_rst_n),  32'd0);
        check("soft_areset", 32'(pll_areset), 32'd0);
        wait_for_state(2'd3, 120, n); check("soft_run_edges", 32'(n), 32'd81);
        tick(3);
        check("soft_dom_all", 32'(dom_rst_n), 32'h1F);

        // Soft request ignored in WAIT_LOCK.
        pll_locked = 1'b0;
        wait_for_state(2'd1, 40, n);  check("wl_entry_edges", 32'(n), 32'd11);
        soft_rst_req = 1'b1;
        tick(1);
        soft_rst_req = 1'b0;
        check("wl_soft_ignored", 32'(seq_state), 32'd1);
        tick(2);
        check("wl_soft_still",   32'(seq_state),     32'd1);
        check("wl_lost_cnt",     32'(lock_lost_cnt), 32'd2);

        // One-cycle lock glitch restarts the stability count.
        pll_locked = 1'b1;
        tick(30);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_for_state(2'd2, 120, n); check("glitch_release_edges", 32'(n), 32'd66);
        wait_for_state(2'd3, 120, n); check("glitch_run_edges",     32'(n), 32'd81);

        // Lock never comes back: WAIT_LOCK times out and PLL reset repeats.
        tick(2);
        pll_locked = 1'b0;
        wait_for_state(2'd1, 40, n);  check("tmo_entry_edges", 32'(n), 32'd11);
        wait_for_state(2'd0, 400, n); check("tmo_edges",       32'(n), 32'd300);
        wait_for_state(2'd1, 20, n);  check("tmo_pll_edges",   32'(n), 32'd8);
        check("tmo_lost_cnt", 32'(lock_lost_cnt), 32'd3);

        // Repeated lock losses saturate the counter.
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b1;
            wait_for_state(2'd2, 150, n);
            pll_locked = 1'b0;
            wait_for_state(2'd0, 10, n);
        end
        check("sat_lost_cnt", 32'(lock_lost_cnt), 32'd255);

        // External reset mid-RELEASE, with domain 3's clock stopped.
        dom_en[3]  = 1'b0;
        pll_locked = 1'b1;
        wait_for_state(2'd2, 150, n);
        tick(48);
        tick(2);
        check("xr_pre_dom", 32'(dom_rst_n), 32'h07);
        ext_rst_n = 1'b0;
        #2;
        check("xr_state",  32'(seq_state),     32'd0);
        check("xr_areset", 32'(pll_areset),    32'd1);
        check("xr_done",   32'(seq_done),      32'd0);
        check("xr_lost",   32'(lock_lost_cnt), 32'd0);
        check("xr_dom",    32'(dom_rst_n),     32'd0);
        tick(2);
        ext_rst_n = 1'b1;
        wait_for_state(2'd3, 200, n); check("xr_run_edges", 32'(n), 32'd155);
        tick(3);
        check("xr_dom3_held", 32'(dom_rst_n), 32'h17);
        dom_en[3] = 1'b1;
        tick(3);
        check("xr_dom3_resumed", 32'(dom_rst_n), 32'h1F);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
